xor_down_stage: RTL and testbench

- Registered, handshaked successor of the combinational key/domain-separation XOR at the bottom of the ASCON permutation datapath.
- Holds its own key register, loaded separately, so the key does not need to be driven on every transaction.
- Applies one of four XOR operations to a type_state (S0..S4, 64-bit lanes) and presents the result through a one-entry valid/ready output register.
- Sits between the permutation round core and the control FSM. Supports 128-bit and 160-bit key variants.

---
 rtl/xor_down_stage.sv | 109 ++++++++++
 tb/tb_xor_down_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_down_stage.sv
// rtl/xor_down_stage.sv - registered key/domain-separation XOR stage with a one-entry valid/ready output
// Lane Si of a state occupies bits [64*i +: 64], so S0 sits in the low bits.
module xor_down_stage #(
    parameter int KEY_W    = 128,
    parameter int DSEP_BIT = 63
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             key_load_i,
    output logic             key_valid_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [319:0]     state_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [319:0]     state_o,
    output logic             err_o,
    input  logic             clr_err_i
);
    typedef enum logic [1:0] {
        OP_PASS     = 2'b00,
        OP_KEY_LOW  = 2'b01,
        OP_DSEP     = 2'b10,
        OP_KEY_HIGH = 2'b11
    } op_e;

    op_e              op;
    logic [KEY_W-1:0] key_r;
    logic [63:0]      kw0;
    logic [63:0]      kw1;
    logic [63:0]      kw2;
    logic             accept;
    logic             key_op;
    logic             key_miss;
    logic [4:0][63:0] lanes;

    generate
        if (KEY_W == 160) begin : g_kw2_wide
            assign kw2 = {32'b0, key_r[KEY_W-1:128]};
        end else if (KEY_W == 128) begin : g_kw2_narrow
            assign kw2 = '0;
        end else begin : g_bad_key_w
            $error("xor_down_stage: KEY_W must be 128 or 160");
        end
        if (DSEP_BIT < 0 || DSEP_BIT > 63) begin : g_bad_dsep_bit
            $error("xor_down_stage: DSEP_BIT must be in 0..63");
        end
    endgenerate

    assign kw0        = key_r[63:0];
    assign kw1        = key_r[127:64];
    assign op         = op_e'(op_i);
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign key_op     = (op == OP_KEY_LOW) || (op == OP_KEY_HIGH);
    assign key_miss   = accept && key_op && !key_valid_o;

    // A key operation without a loaded key degrades to PASS; err_o reports it.
    always_comb begin
        lanes = state_i;
        case (op)
            OP_KEY_LOW: begin
                if (key_valid_o) begin
                    lanes[3] = lanes[3] ^ kw0;
                    lanes[4] = lanes[4] ^ kw1;
                    lanes[2] = lanes[2] ^ kw2;
                end
            end
            OP_KEY_HIGH: begin
                if (key_valid_o) begin
                    lanes[1] = lanes[1] ^ kw0;
                    lanes[2] = lanes[2] ^ kw1;
                    lanes[0] = lanes[0] ^ kw2;
                end
            end
            OP_DSEP: lanes[4][DSEP_BIT] = ~lanes[4][DSEP_BIT];
            default: lanes = state_i;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            key_r       <= '0;
            key_valid_o <= 1'b0;
            out_valid_o <= 1'b0;
            state_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            // The result above already used the pre-load key_r.
            if (key_load_i) begin
                key_r       <= key_i;
                key_valid_o <= 1'b1;
            end
            if (accept) begin
                state_o     <= lanes;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (key_miss) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xor_down_stage.sv
// tb/tb_xor_down_stage.sv - self-checking bench for xor_down_stage (128-bit/bit-63 and 160-bit/bit-0 instances)
module tb_xor_down_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] key;
    logic         key_load;
    logic         in_valid;
    logic         out_ready;
    logic         clr_err;
    logic [1:0]   op;
    logic [319:0] st;

    logic         a_kv, a_ir, a_ov, a_err;
    logic [319:0] a_so;
    logic         b_kv, b_ir, b_ov, b_err;
    logic [319:0] b_so;

    int n_pass  = 0;
    int n_total = 0;

    logic [159:0] m_key;
    bit           m_kv, m_err, m_ov;
    logic [319:0] m_sa, m_sb;
    logic [319:0] q_a[$];

    always #5 clk = ~clk;

    xor_down_stage #(.KEY_W(128), .DSEP_BIT(63)) dut_a (
        .clock_i(clk), .reset_i(rst), .key_i(key[127:0]), .key_load_i(key_load),
        .key_valid_o(a_kv), .in_valid_i(in_valid), .in_ready_o(a_ir), .op_i(op),
        .state_i(st), .out_valid_o(a_ov), .out_ready_i(out_ready), .state_o(a_so),
        .err_o(a_err), .clr_err_i(clr_err)
    );

    xor_down_stage #(.KEY_W(160), .DSEP_BIT(0)) dut_b (
        .clock_i(clk), .reset_i(rst), .key_i(key), .key_load_i(key_load),
        .key_valid_o(b_kv), .in_valid_i(in_valid), .in_ready_o(b_ir), .op_i(op),
        .state_i(st), .out_valid_o(b_ov), .out_ready_i(out_ready), .state_o(b_so),
        .err_o(b_err), .clr_err_i(clr_err)
    );

    function automatic logic [319:0] lanes5(input logic [63:0] s4, input logic [63:0] s3,
                                            input logic [63:0] s2, input logic [63:0] s1,
                                            input logic [63:0] s0);
        return {s4, s3, s2, s1, s0};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: apply the operation to lane words directly.
    function automatic logic [319:0] ref_xor(input logic [319:0] s, input logic [1:0] o,
                                             input logic [159:0] k, input bit kv,
                                             input bit wide, input int dbit);
        logic [63:0]  ln [5];
        logic [63:0]  k0, k1, k2;
        logic [319:0] r;
        for (int i = 0; i < 5; i++) ln[i] = s[64*i +: 64];
        k0 = k[63:0];
        k1 = k[127:64];
        k2 = wide ? {32'h0, k[159:128]} : 64'h0;
        if (o == 2'b01 && kv) begin ln[3] ^= k0; ln[4] ^= k1; ln[2] ^= k2; end
        if (o == 2'b11 && kv) begin ln[1] ^= k0; ln[2] ^= k1; ln[0] ^= k2; end
        if (o == 2'b10) ln[4][dbit] ^= 1'b1;
        for (int i = 0; i < 5; i++) r[64*i +: 64] = ln[i];
        return r;
    endfunction

    // Advance the model by one edge from the currently driven inputs, then step the clock.
    task automatic tick();
        bit acc;
        acc = in_valid && (!m_ov || out_ready);
        if (rst) begin
            m_key = '0; m_kv = 0; m_err = 0; m_ov = 0; m_sa = '0; m_sb = '0;
            q_a.delete();
        end else begin
            if (acc) begin
                m_sa = ref_xor(st, op, {32'h0, m_key[127:0]}, m_kv, 1'b0, 63);
                m_sb = ref_xor(st, op, m_key, m_kv, 1'b1, 0);
                q_a.push_back(m_sa);
            end
            if (acc && op[0] && !m_kv) m_err = 1;
            else if (clr_err) m_err = 0;
            if (acc) m_ov = 1;
            else if (out_ready) m_ov = 0;
            if (key_load) begin m_key = key; m_kv = 1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; key_load = 0; in_valid = 0; clr_err = 0; out_ready = 1; op = 2'b00; st = '0;
    endtask

    task automatic test_reset();
        rst = 1; key_load = 1; key = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_valid = 1; out_ready = 1; clr_err = 0; op = 2'b01; st = rand_state();
        tick();
        tick();
        idle();
        #1;
        n_total++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", a_ov); else n_pass++;
        n_total++; if (a_kv !== 1'b0 || b_kv !== 1'b0) $display("FAIL reset_key_valid: got %0b/%0b want 0/0", a_kv, b_kv); else n_pass++;
        n_total++; if (a_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", a_err); else n_pass++;
        n_total++; if (a_ir !== 1'b1 || b_ir !== 1'b1) $display("FAIL reset_in_ready: got %0b/%0b want 1/1", a_ir, b_ir); else n_pass++;
        n_total++; if (a_so !== '0 || b_so !== '0) $display("FAIL reset_state: got %h / %h want 0", a_so, b_so); else n_pass++;
    endtask

    task automatic test_missing_key();
        logic [319:0] s;
        idle();
        s = rand_state(); st = s; op = 2'b01; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== s || b_so !== s) $display("FAIL nokey_passthru: got %h want %h", a_so, s); else n_pass++;
        n_total++; if (a_err !== 1'b1 || b_err !== 1'b1) $display("FAIL nokey_err_set: got %0b/%0b want 1", a_err, b_err); else n_pass++;
        n_total++; if (a_ov !== 1'b1) $display("FAIL nokey_out_valid: got %0b want 1", a_ov); else n_pass++;
        st = rand_state(); op = 2'b00; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_err !== 1'b1 || a_so !== m_sa) $display("FAIL nokey_err_sticky: err %0b state %h want 1 %h", a_err, a_so, m_sa); else n_pass++;
        clr_err = 1;
        tick();
        idle();
        n_total++; if (a_err !== 1'b0 || b_err !== 1'b0) $display("FAIL nokey_err_clear: got %0b/%0b want 0", a_err, b_err); else n_pass++;
        s = rand_state(); st = s; op = 2'b11; in_valid = 1; clr_err = 1;
        tick();
        idle();
        n_total++; if (a_err !== 1'b1 || b_so !== s) $display("FAIL nokey_clr_vs_new_err: err %0b state %h want 1 %h", a_err, b_so, s); else n_pass++;
    endtask

    task automatic test_key_ops();
        idle();
        key = {32'hDEADBEEF, 128'h00112233445566778899AABBCCDDEEFF}; key_load = 1; clr_err = 1;
        tick();
        idle();
        n_total++; if (a_kv !== 1'b1 || b_kv !== 1'b1 || a_err !== 1'b0) $display("FAIL key_load: kv %0b/%0b err %0b want 1/1 0", a_kv, b_kv, a_err); else n_pass++;
        st = '0; op = 2'b01; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== lanes5(64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0, 64'h0, 64'h0)) $display("FAIL key_low_128: got %h", a_so); else n_pass++;
        n_total++; if (b_so !== lanes5(64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h00000000DEADBEEF, 64'h0, 64'h0)) $display("FAIL key_low_160: got %h", b_so); else n_pass++;
        st = '0; op = 2'b11; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== lanes5(64'h0, 64'h0, 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0)) $display("FAIL key_high_128: got %h", a_so); else n_pass++;
        n_total++; if (b_so !== lanes5(64'h0, 64'h0, 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h00000000DEADBEEF)) $display("FAIL key_high_160: got %h", b_so); else n_pass++;
        st = '0; op = 2'b10; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== lanes5(64'h8000000000000000, 64'h0, 64'h0, 64'h0, 64'h0)) $display("FAIL dsep_bit63: got %h", a_so); else n_pass++;
        n_total++; if (b_so !== lanes5(64'h1, 64'h0, 64'h0, 64'h0, 64'h0)) $display("FAIL dsep_bit0: got %h", b_so); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            st = rand_state(); op = 2'($urandom_range(0, 3)); in_valid = 1; out_ready = 1;
            tick();
            n_total++; if (a_so !== m_sa || b_so !== m_sb || a_ov !== m_ov || a_err !== m_err) $display("FAIL random_op[%0d]: op %0d got %h / %h want %h / %h", i, op, a_so, b_so, m_sa, m_sb); else n_pass++;
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [319:0] held;
        logic [319:0] exp;
        int           pops;
        idle();
        tick();
        q_a.delete();
        pops = 0;
        st = rand_state(); op = 2'($urandom_range(0, 3)); in_valid = 1; out_ready = 0;
        tick();
        held = a_so;
        n_total++; if (held !== m_sa) $display("FAIL stall_first_result: got %h want %h", held, m_sa); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            st = rand_state(); op = 2'($urandom_range(0, 3)); in_valid = 1; out_ready = 0;
            #1;
            n_total++; if (a_ir !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, a_ir); else n_pass++;
            tick();
            n_total++; if (a_so !== held || a_ov !== 1'b1) $display("FAIL stall_hold[%0d]: got %h v%0b want %h v1", i, a_so, a_ov, held); else n_pass++;
        end
        for (int i = 0; i < 13; i++) begin
            if (i < 12) begin
                st = rand_state(); op = 2'($urandom_range(0, 3)); in_valid = 1;
            end else begin
                in_valid = 0;
            end
            out_ready = 1;
            #1;
            if (a_ov && out_ready) begin
                n_total++;
                if (q_a.size() == 0) begin
                    $display("FAIL stream_extra_output[%0d]: got %h want none", i, a_so);
                end else begin
                    exp = q_a.pop_front();
                    pops++;
                    if (a_so !== exp) $display("FAIL stream_order[%0d]: got %h want %h", i, a_so, exp); else n_pass++;
                end
            end
            tick();
            if (i < 12) begin
                n_total++; if (a_ov !== 1'b1) $display("FAIL stream_bubble[%0d]: got out_valid %0b want 1", i, a_ov); else n_pass++;
            end
        end
        idle();
        #1;
        n_total++; if (a_ov !== 1'b0 || q_a.size() != 0 || pops != 13) $display("FAIL stream_drain: out_valid %0b left %0d popped %0d want 0 0 13", a_ov, q_a.size(), pops); else n_pass++;
    endtask

    task automatic test_key_coincident();
        idle();
        key = {32'hCAFEF00D, 128'hFEDCBA98765432100F1E2D3C4B5A6978}; key_load = 1;
        st = '0; op = 2'b01; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== lanes5(64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0, 64'h0, 64'h0)) $display("FAIL load_same_cycle_old_key_128: got %h", a_so); else n_pass++;
        n_total++; if (b_so !== lanes5(64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h00000000DEADBEEF, 64'h0, 64'h0)) $display("FAIL load_same_cycle_old_key_160: got %h", b_so); else n_pass++;
        st = '0; op = 2'b01; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_so !== lanes5(64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h0, 64'h0, 64'h0)) $display("FAIL next_uses_new_key_128: got %h", a_so); else n_pass++;
        n_total++; if (b_so !== lanes5(64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h00000000CAFEF00D, 64'h0, 64'h0)) $display("FAIL next_uses_new_key_160: got %h", b_so); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [319:0] s;
        idle();
        st = rand_state(); op = 2'b10; in_valid = 1; out_ready = 0;
        tick();
        n_total++; if (a_ov !== 1'b1) $display("FAIL midreset_pending: got out_valid %0b want 1", a_ov); else n_pass++;
        rst = 1; in_valid = 1; out_ready = 0; st = rand_state();
        tick();
        idle();
        #1;
        n_total++; if (a_ov !== 1'b0 || b_ov !== 1'b0) $display("FAIL midreset_out_valid: got %0b/%0b want 0", a_ov, b_ov); else n_pass++;
        n_total++; if (a_kv !== 1'b0 || b_kv !== 1'b0 || a_so !== '0) $display("FAIL midreset_key_state: kv %0b/%0b state %h want 0", a_kv, b_kv, a_so); else n_pass++;
        s = rand_state(); st = s; op = 2'b01; in_valid = 1;
        tick();
        idle();
        n_total++; if (a_err !== 1'b1 || a_so !== s) $display("FAIL midreset_key_cleared: err %0b state %h want 1 %h", a_err, a_so, s); else n_pass++;
    endtask

    initial begin
        key = '0;
        test_reset();
        test_missing_key();
        test_key_ops();
        test_back_to_back();
        test_key_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
